// File: rtl/cci_mpf_flag_line_pkg.sv
// Completion-line layout shared by the flag writer and the poll reader.
// Also holds the poller state encoding and the c0 request mdata helper.
package cci_mpf_flag_line_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT_RSP,
      ST_BACKOFF,
      ST_DONE
   } t_poll_state;

   localparam int FLAG_BIT  = 0;
   localparam int COUNT_LSB = 64;
   localparam int COUNT_W   = 32;

   localparam int CL_ADDR_W = 42;
   localparam int CL_DATA_W = 512;
   localparam int MDATA_W   = 16;
   localparam int SEQ_W     = 8;
   localparam int PCOUNT_W  = 16;

   function automatic logic [MDATA_W-1:0] make_mdata(
      input logic [7:0]       tag,
      input logic [SEQ_W-1:0] seq
   );
      return {tag, seq};
   endfunction

endpackage

// File: rtl/cci_mpf_flag_poll_reader_timer.sv
// Backoff down-counter between a flag-clear response and the next poll.
// Load sets POLL_INTERVAL; expire is high while the count sits at one.
module poll_backoff_timer #(
   parameter int POLL_INTERVAL = 64
) (
   input  logic clk,
   input  logic reset,
   input  logic load,
   input  logic en,
   output logic expire
);

   localparam int W = $clog2(POLL_INTERVAL + 1);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   // Next count: reload wins, otherwise count down toward zero.
   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = W'(POLL_INTERVAL);
      end else if (en && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   // Count register.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expire = (cnt_q == W'(1));

endmodule

// File: rtl/cci_mpf_flag_poll_reader.sv
// Polls a host completion line over c0 until its done flag is set or the
// poll budget runs out, then reports the counter captured from the line.
module cci_mpf_flag_poll_reader
   import cci_mpf_flag_line_pkg::*;
#(
   parameter int         POLL_INTERVAL = 64,
   parameter int         MAX_POLLS     = 1024,
   parameter logic [7:0] TAG_ID        = 8'hA5
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [CL_ADDR_W-1:0] poll_addr,
   input  logic                 c0TxAlmFull,
   output logic                 rd_req_valid,
   output logic [CL_ADDR_W-1:0] rd_req_addr,
   output logic [MDATA_W-1:0]   rd_req_mdata,
   input  logic                 rd_rsp_valid,
   input  logic [MDATA_W-1:0]   rd_rsp_mdata,
   input  logic [CL_DATA_W-1:0] rd_rsp_data,
   output logic                 busy,
   output logic                 done,
   output logic                 result_valid,
   output logic [COUNT_W-1:0]   result_count,
   output logic                 timeout,
   output logic [PCOUNT_W-1:0]  poll_count
);

   t_poll_state state_q;
   t_poll_state state_d;

   logic [CL_ADDR_W-1:0] addr_q;
   logic [CL_ADDR_W-1:0] addr_d;
   logic [SEQ_W-1:0]     seq_q;
   logic [SEQ_W-1:0]     seq_d;
   logic [SEQ_W-1:0]     out_seq_q;
   logic [SEQ_W-1:0]     out_seq_d;
   logic                 req_valid_q;
   logic                 req_valid_d;
   logic [MDATA_W-1:0]   req_mdata_q;
   logic [MDATA_W-1:0]   req_mdata_d;
   logic                 result_valid_q;
   logic                 result_valid_d;
   logic [COUNT_W-1:0]   result_count_q;
   logic [COUNT_W-1:0]   result_count_d;
   logic                 timeout_q;
   logic                 timeout_d;
   logic [PCOUNT_W-1:0]  poll_count_q;
   logic [PCOUNT_W-1:0]  poll_count_d;

   logic issue;
   logic run_start;
   logic rsp_match;
   logic rsp_flag;
   logic poll_limit;
   logic tmr_load;
   logic tmr_en;
   logic tmr_expire;

   // Only the flag and counter fields of the line matter here.
   logic unused_rsp_bits;
   assign unused_rsp_bits = ^{rd_rsp_data[CL_DATA_W-1:COUNT_LSB+COUNT_W],
                              rd_rsp_data[COUNT_LSB-1:FLAG_BIT+1]};

   assign run_start  = (state_q == ST_IDLE) && start;
   assign rsp_match  = rd_rsp_valid &&
                       (rd_rsp_mdata == make_mdata(TAG_ID, out_seq_q));
   assign rsp_flag   = rd_rsp_data[FLAG_BIT];
   assign poll_limit = (MAX_POLLS != 0) &&
                       (poll_count_q == PCOUNT_W'(MAX_POLLS));

   poll_backoff_timer #(
      .POLL_INTERVAL (POLL_INTERVAL)
   ) u_timer (
      .clk    (clk),
      .reset  (reset),
      .load   (tmr_load),
      .en     (tmr_en),
      .expire (tmr_expire)
   );

   // FSM state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (start) state_d = ST_ISSUE;
         end
         ST_ISSUE: begin
            if (!c0TxAlmFull) state_d = ST_WAIT_RSP;
         end
         ST_WAIT_RSP: begin
            if (rsp_match) begin
               if (rsp_flag || poll_limit) state_d = ST_DONE;
               else                        state_d = ST_BACKOFF;
            end
         end
         ST_BACKOFF: begin
            if (tmr_expire) state_d = ST_ISSUE;
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // FSM outputs: status, request strobe and timer control.
   always_comb begin
      busy     = (state_q != ST_IDLE);
      done     = (state_q == ST_DONE);
      issue    = (state_q == ST_ISSUE) && !c0TxAlmFull;
      tmr_en   = (state_q == ST_BACKOFF);
      tmr_load = (state_q == ST_WAIT_RSP) && rsp_match &&
                 !rsp_flag && !poll_limit;
   end

   // Datapath: run setup, request fields, sequence and result capture.
   always_comb begin
      addr_d         = addr_q;
      seq_d          = seq_q;
      out_seq_d      = out_seq_q;
      req_valid_d    = issue;
      req_mdata_d    = req_mdata_q;
      result_valid_d = result_valid_q;
      result_count_d = result_count_q;
      timeout_d      = timeout_q;
      poll_count_d   = poll_count_q;

      if (run_start) begin
         addr_d         = poll_addr;
         result_valid_d = 1'b0;
         result_count_d = '0;
         timeout_d      = 1'b0;
         poll_count_d   = '0;
      end

      if (issue) begin
         req_mdata_d = make_mdata(TAG_ID, seq_q);
         out_seq_d   = seq_q;
         seq_d       = seq_q + 1'b1;
         if (poll_count_q != '1) begin
            poll_count_d = poll_count_q + 1'b1;
         end
      end

      if ((state_q == ST_WAIT_RSP) && rsp_match) begin
         if (rsp_flag) begin
            result_count_d = rd_rsp_data[COUNT_LSB +: COUNT_W];
            result_valid_d = 1'b1;
         end else if (poll_limit) begin
            timeout_d = 1'b1;
         end
      end
   end

   // Datapath registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         addr_q         <= '0;
         seq_q          <= '0;
         out_seq_q      <= '0;
         req_valid_q    <= 1'b0;
         req_mdata_q    <= '0;
         result_valid_q <= 1'b0;
         result_count_q <= '0;
         timeout_q      <= 1'b0;
         poll_count_q   <= '0;
      end else begin
         addr_q         <= addr_d;
         seq_q          <= seq_d;
         out_seq_q      <= out_seq_d;
         req_valid_q    <= req_valid_d;
         req_mdata_q    <= req_mdata_d;
         result_valid_q <= result_valid_d;
         result_count_q <= result_count_d;
         timeout_q      <= timeout_d;
         poll_count_q   <= poll_count_d;
      end
   end

   assign rd_req_valid = req_valid_q;
   assign rd_req_addr  = addr_q;
   assign rd_req_mdata = req_mdata_q;
   assign result_valid = result_valid_q;
   assign result_count = result_count_q;
   assign timeout      = timeout_q;
   assign poll_count   = poll_count_q;

endmodule

// File: tb/tb_cci_mpf_flag_poll_reader.sv
// Bench for the completion-line poller: table vectors, random runs
// against a run-level model, and reset-abort corner cases.
`timescale 1ns/1ps
module tb_cci_mpf_flag_poll_reader;
   import cci_mpf_flag_line_pkg::*;

   localparam int         PI  = 4;
   localparam int         MP  = 3;
   localparam logic [7:0] TAG = 8'hA5;

   logic                 clk = 1'b0;
   logic                 reset;
   logic                 start;
   logic [CL_ADDR_W-1:0] poll_addr;
   logic                 c0TxAlmFull;
   logic                 rd_req_valid;
   logic [CL_ADDR_W-1:0] rd_req_addr;
   logic [MDATA_W-1:0]   rd_req_mdata;
   logic                 rd_rsp_valid;
   logic [MDATA_W-1:0]   rd_rsp_mdata;
   logic [CL_DATA_W-1:0] rd_rsp_data;
   logic                 busy;
   logic                 done;
   logic                 result_valid;
   logic [COUNT_W-1:0]   result_count;
   logic                 timeout;
   logic [PCOUNT_W-1:0]  poll_count;

   cci_mpf_flag_poll_reader #(
      .POLL_INTERVAL (PI),
      .MAX_POLLS     (MP),
      .TAG_ID        (TAG)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .poll_addr    (poll_addr),
      .c0TxAlmFull  (c0TxAlmFull),
      .rd_req_valid (rd_req_valid),
      .rd_req_addr  (rd_req_addr),
      .rd_req_mdata (rd_req_mdata),
      .rd_rsp_valid (rd_rsp_valid),
      .rd_rsp_mdata (rd_rsp_mdata),
      .rd_rsp_data  (rd_rsp_data),
      .busy         (busy),
      .done         (done),
      .result_valid (result_valid),
      .result_count (result_count),
      .timeout      (timeout),
      .poll_count   (poll_count)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;
   int exp_seq = 0;
   int last_rsp = 0;

   typedef struct {
      logic [41:0] addr;
      int          nclr;
      logic [31:0] cnt;
      int          lat;
      int          junk;
      int          alm;
      bit          smid;
      bit          sdone;
      int          e_polls;
      bit          e_valid;
      bit          e_to;
   } vec_t;

   vec_t vecs[5];

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                  name, act, exp, cyc);
      end
   endtask

   task automatic send_rsp(input logic [15:0] md, input bit flag,
                           input logic [31:0] cnt);
      logic [511:0] line;
      for (int i = 0; i < 16; i++) line[i*32 +: 32] = $urandom();
      line[FLAG_BIT] = flag;
      line[COUNT_LSB +: COUNT_W] = cnt;
      rd_rsp_valid = 1'b1;
      rd_rsp_mdata = md;
      rd_rsp_data  = line;
      @(negedge clk);
      rd_rsp_valid = 1'b0;
      rd_rsp_mdata = 16'($urandom());
   endtask

   // One complete run; the bench sits just after a negedge on entry/exit.
   task automatic do_run(input vec_t v);
      int k;
      logic [7:0] s;
      @(negedge clk);
      poll_addr   = v.addr;
      start       = 1'b1;
      c0TxAlmFull = (v.alm > 0);
      @(negedge clk);
      start     = 1'b0;
      poll_addr = 42'({$urandom(), $urandom()});
      chk("busy_run", busy, 1);
      for (int p = 0; p < v.e_polls; p++) begin
         if (p == 0) begin
            for (int i = 0; i < v.alm; i++) begin
               chk("alm_hold", rd_req_valid, 0);
               @(negedge clk);
            end
            c0TxAlmFull = 1'b0;
            chk("req_early", rd_req_valid, 0);
            @(negedge clk);
            chk("req_latency", rd_req_valid, 1);
         end else begin
            k = 0;
            while (rd_req_valid !== 1'b1 && k < 200) begin
               @(negedge clk);
               k++;
            end
            chk("req_seen", rd_req_valid, 1);
            chk("backoff_gap", 64'((cyc - last_rsp) >= PI + 1), 1);
         end
         s = 8'(exp_seq);
         chk("req_addr", rd_req_addr, v.addr);
         chk("req_mdata", rd_req_mdata, {TAG, s});
         chk("poll_count_run", poll_count, 64'(p + 1));
         exp_seq = (exp_seq + 1) % 256;
         for (int i = 0; i < v.lat; i++) begin
            @(negedge clk);
            chk("one_outstanding", rd_req_valid, 0);
            start = v.smid && (i == 0);
            if (start) poll_addr = ~v.addr;
         end
         start = 1'b0;
         if (v.junk != 0) begin
            send_rsp((v.junk == 1) ? 16'h1200 : {TAG, s + 8'd1},
                     1'b1, 32'hDEAD_BEEF);
            chk("junk_ignored", done, 0);
            chk("junk_busy", busy, 1);
         end
         last_rsp = cyc;
         send_rsp({TAG, s}, (p == v.nclr), v.cnt);
      end
      chk("done_pulse", done, 1);
      chk("result_valid", result_valid, v.e_valid);
      chk("timeout", timeout, v.e_to);
      chk("result_count", result_count, v.e_valid ? v.cnt : 32'h0);
      chk("poll_count", poll_count, v.e_polls);
      start     = v.sdone;
      poll_addr = v.addr + 42'h40;
      @(negedge clk);
      start = 1'b0;
      chk("done_once", done, 0);
      chk("idle_busy", busy, 0);
      @(negedge clk);
      chk("start_in_done_ignored", busy, 0);
      chk("result_sticky", result_valid, v.e_valid);
   endtask

   // Run-level model: polls stop at the first set flag or at the budget.
   function automatic vec_t model(input vec_t v);
      vec_t r = v;
      r.e_valid = (v.nclr + 1 <= MP);
      r.e_to    = !r.e_valid;
      r.e_polls = r.e_valid ? v.nclr + 1 : MP;
      return r;
   endfunction

   initial begin
      vec_t rv;
      logic [7:0] s;

      vecs[0] = '{42'h1000, 0, 32'h3FF, 5, 0, 0, 0, 0, 1, 1, 0};
      vecs[1] = '{42'h2040, 2, 32'h7, 3, 0, 0, 0, 0, 3, 1, 0};
      vecs[2] = '{42'h3080, 9, 32'h11, 2, 0, 0, 0, 0, 3, 0, 1};
      vecs[3] = '{42'h40C0, 0, 32'h55, 4, 1, 10, 1, 0, 1, 1, 0};
      vecs[4] = '{42'h3FF_FFFF_FFC0, 1, 32'hFFFF_FFFF, 2, 2, 0, 0, 1,
                  2, 1, 0};

      reset        = 1'b1;
      start        = 1'b0;
      poll_addr    = '0;
      c0TxAlmFull  = 1'b0;
      rd_rsp_valid = 1'b0;
      rd_rsp_mdata = '0;
      rd_rsp_data  = '0;
      repeat (3) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_req_valid", rd_req_valid, 0);
      chk("rst_req_addr", rd_req_addr, 0);
      chk("rst_req_mdata", rd_req_mdata, 0);
      chk("rst_results",
          {result_valid, timeout, result_count, poll_count}, 0);
      reset = 1'b0;
      @(negedge clk);

      foreach (vecs[i]) do_run(vecs[i]);

      for (int r = 0; r < 110; r++) begin
         rv.addr  = {$urandom(), 10'($urandom())} & ~42'h3F;
         rv.nclr  = $urandom_range(0, 4);
         rv.cnt   = $urandom();
         rv.lat   = $urandom_range(1, 6);
         rv.junk  = $urandom_range(0, 2);
         rv.alm   = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
         rv.smid  = $urandom_range(0, 1);
         rv.sdone = $urandom_range(0, 1);
         do_run(model(rv));
      end

      // Reset while a request is outstanding, then a late response.
      @(negedge clk);
      poll_addr = 42'h5000;
      start     = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      chk("abort_req", rd_req_valid, 1);
      s = 8'(exp_seq);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("abort_busy", busy, 0);
      chk("abort_outputs",
          {rd_req_valid, done, result_valid, timeout, result_count,
           poll_count}, 0);
      chk("abort_req_fields", {rd_req_addr, rd_req_mdata}, 0);
      exp_seq = 0;
      send_rsp({TAG, s}, 1'b1, 32'h1234);
      for (int i = 0; i < 8; i++) begin
         chk("late_rsp_quiet", {done, busy, result_valid}, 0);
         @(negedge clk);
      end

      // Sequence restarts at zero after reset.
      do_run('{42'h1000, 0, 32'h3FF, 5, 0, 0, 0, 0, 1, 1, 0});

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule
